seg7_display_ctrl: RTL and testbench

- Memory-mapped seven-segment display controller downstream of the pipelined RISC-V core's data-memory/store path.
- Core stores a 32-bit value and a control word; block time-multiplexes NO_OF_SEGS hex digits onto the board's common anode/cathode lines.
- Owns the top-level anode/display outputs; core sees it as a small peripheral selected by the load/store address decoder.

---
 rtl/seg7_display_ctrl.sv | 114 +++++++++++
 tb/tb_seg7_display_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg7_display_ctrl.sv
// rtl/seg7_display_ctrl.sv - memory-mapped multiplexed seven-segment hex display controller
// Scans NO_OF_SEGS digits of the VALUE register onto active-low anode/cathode pins.
module seg7_display_ctrl #(
    parameter int DW          = 32,
    parameter int NO_OF_SEGS  = 8,
    parameter int REFRESH_DIV = 100000,
    parameter int ADDRW       = 12
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sel_i,
    input  logic                  we_i,
    input  logic [ADDRW-1:0]      addr_i,
    input  logic [DW-1:0]         wdata_i,
    output logic [DW-1:0]         rdata_o,
    output logic [NO_OF_SEGS-1:0] anode,
    output logic [6:0]            display
);

    localparam int IDXW     = (NO_OF_SEGS > 1) ? $clog2(NO_OF_SEGS) : 1;
    localparam int CNTW     = $clog2(REFRESH_DIV);
    localparam int NIB_BITS = NO_OF_SEGS * 4;

    logic [DW-1:0]   value_q;
    logic [1:0]      ctrl_q;
    logic [CNTW-1:0] cnt_q;
    logic [IDXW-1:0] idx_q;
    logic [3:0]      nib;
    logic            blank_digit;
    logic            unused_addr;

    assign unused_addr = ^{addr_i[ADDRW-1:4], addr_i[1:0]};

    function automatic logic [6:0] hex_to_seg(input logic [3:0] n);
        case (n)
            4'h0: hex_to_seg = 7'h40;
            4'h1: hex_to_seg = 7'h79;
            4'h2: hex_to_seg = 7'h24;
            4'h3: hex_to_seg = 7'h30;
            4'h4: hex_to_seg = 7'h19;
            4'h5: hex_to_seg = 7'h12;
            4'h6: hex_to_seg = 7'h02;
            4'h7: hex_to_seg = 7'h78;
            4'h8: hex_to_seg = 7'h00;
            4'h9: hex_to_seg = 7'h10;
            4'hA: hex_to_seg = 7'h08;
            4'hB: hex_to_seg = 7'h03;
            4'hC: hex_to_seg = 7'h46;
            4'hD: hex_to_seg = 7'h21;
            4'hE: hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    assign nib = 4'(value_q[NIB_BITS-1:0] >> {idx_q, 2'b00});

    // Leading-zero blanking: this digit and every more significant one are zero; digit 0 always shows.
    assign blank_digit = ctrl_q[1] && (idx_q != '0) &&
                         ((value_q[NIB_BITS-1:0] >> {idx_q, 2'b00}) == '0);

    always_comb begin
        rdata_o = '0;
        if (sel_i) begin
            case (addr_i[3:2])
                2'd0:    rdata_o = value_q;
                2'd1:    rdata_o = DW'(ctrl_q);
                2'd2:    rdata_o = DW'(idx_q);
                default: rdata_o = '0;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            value_q <= '0;
            ctrl_q  <= '0;
        end else if (sel_i && we_i) begin
            case (addr_i[3:2])
                2'd0:    value_q <= wdata_i;
                2'd1:    ctrl_q  <= wdata_i[1:0];
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (!ctrl_q[0]) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else if (cnt_q == CNTW'(REFRESH_DIV - 1)) begin
            cnt_q <= '0;
            idx_q <= (idx_q == IDXW'(NO_OF_SEGS - 1)) ? '0 : idx_q + 1'b1;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            anode   <= '1;
            display <= 7'h7F;
        end else if (!ctrl_q[0] || blank_digit) begin
            anode   <= '1;
            display <= 7'h7F;
        end else begin
            anode   <= ~(NO_OF_SEGS'(1) << idx_q);
            display <= hex_to_seg(nib);
        end
    end

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb/tb_seg7_display_ctrl.sv - directed self-checking bench for seg7_display_ctrl
module tb_seg7_display_ctrl;

    localparam int DW = 32;
    localparam int NS = 8;
    localparam int RD = 4;
    localparam int AW = 12;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          sel_i;
    logic          we_i;
    logic [AW-1:0] addr_i;
    logic [DW-1:0] wdata_i;
    logic [DW-1:0] rdata_o;
    logic [NS-1:0] anode;
    logic [6:0]    display;

    int checks = 0;
    int errors = 0;
    logic [31:0] rd_val;

    logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    logic [6:0] scan_exp [8] = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
    logic [7:0] an_exp   [8] = '{8'hFE, 8'hFD, 8'hFB, 8'hF7, 8'hEF, 8'hDF, 8'hBF, 8'h7F};

    always #5 clk_i = ~clk_i;

    seg7_display_ctrl #(
        .DW(DW), .NO_OF_SEGS(NS), .REFRESH_DIV(RD), .ADDRW(AW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i), .sel_i(sel_i), .we_i(we_i), .addr_i(addr_i),
        .wdata_i(wdata_i), .rdata_o(rdata_o), .anode(anode), .display(display)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
        sel_i = 1'b1; we_i = 1'b1; addr_i = a; wdata_i = d;
        @(posedge clk_i);
        #1;
        sel_i = 1'b0; we_i = 1'b0;
    endtask

    task automatic rd(input logic [AW-1:0] a, output logic [31:0] d);
        sel_i = 1'b1; we_i = 1'b0; addr_i = a;
        #1;
        d = rdata_o;
        sel_i = 1'b0;
    endtask

    task automatic settle();
        @(negedge clk_i);
        @(negedge clk_i);
    endtask

    initial begin
        rst_i = 1'b0; sel_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0;
        repeat (3) @(negedge clk_i);
        chk("rst_anode", anode, 8'hFF);
        chk("rst_display", display, 7'h7F);
        for (int a = 0; a < 4; a++) begin
            rd(AW'(a * 4), rd_val);
            chk($sformatf("rst_rdata_off%0d", a), rd_val, 32'h0);
        end
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(negedge clk_i);
        chk("post_rst_anode", anode, 8'hFF);
        chk("post_rst_display", display, 7'h7F);

        wr(12'h0, 32'h1234ABCD);
        wr(12'h4, 32'h1);
        settle();
        for (int d = 0; d < NS; d++) begin
            rd(12'h8, rd_val);
            chk($sformatf("scan_status_d%0d", d), rd_val, 32'(d));
            for (int k = 0; k < RD; k++) begin
                chk($sformatf("scan_anode_d%0d_c%0d", d, k), anode, an_exp[d]);
                chk($sformatf("scan_disp_d%0d_c%0d", d, k), display, scan_exp[d]);
                @(negedge clk_i);
            end
        end
        chk("wrap_anode", anode, 8'hFE);
        chk("wrap_display", display, 7'h21);

        wr(12'h4, 32'h0);
        wr(12'h0, 32'h000000A5);
        wr(12'h4, 32'h3);
        settle();
        for (int d = 0; d < NS; d++) begin
            chk($sformatf("blank_a5_anode_d%0d", d), anode,
                (d == 0) ? 8'hFE : (d == 1) ? 8'hFD : 8'hFF);
            chk($sformatf("blank_a5_disp_d%0d", d), display,
                (d == 0) ? 7'h12 : (d == 1) ? 7'h08 : 7'h7F);
            repeat (RD) @(negedge clk_i);
        end

        wr(12'h4, 32'h0);
        wr(12'h0, 32'h0);
        wr(12'h4, 32'h3);
        settle();
        for (int d = 0; d < NS; d++) begin
            chk($sformatf("blank_0_anode_d%0d", d), anode, (d == 0) ? 8'hFE : 8'hFF);
            chk($sformatf("blank_0_disp_d%0d", d), display, (d == 0) ? 7'h40 : 7'h7F);
            repeat (RD) @(negedge clk_i);
        end

        chk("midscan_before", display, 7'h40);
        wr(12'h0, 32'h9);
        settle();
        chk("midscan_disp", display, 7'h10);
        chk("midscan_anode", anode, 8'hFE);

        wr(12'h4, 32'h0);
        settle();
        chk("dis_anode", anode, 8'hFF);
        chk("dis_display", display, 7'h7F);
        rd(12'h8, rd_val);
        chk("dis_status", rd_val, 32'h0);

        wr(12'h4, 32'h1);
        settle();
        chk("reen_anode", anode, 8'hFE);
        chk("reen_display", display, 7'h10);
        #2;
        rst_i = 1'b0;
        #1;
        chk("async_rst_anode", anode, 8'hFF);
        chk("async_rst_display", display, 7'h7F);
        rd(12'h0, rd_val);
        chk("async_rst_value", rd_val, 32'h0);
        rd(12'h4, rd_val);
        chk("async_rst_ctrl", rd_val, 32'h0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        chk("post_async_anode", anode, 8'hFF);

        wr(12'h4, 32'h1);
        for (int n = 0; n < 16; n++) begin
            wr(12'h0, {8{4'(n)}});
            settle();
            chk($sformatf("decode_%0h", n), display, seg_tab[n]);
        end

        wr(12'h0, 32'h12345678);
        wr(12'h8, 32'hDEADBEEF);
        wr(12'hC, 32'hCAFEF00D);
        rd(12'h0, rd_val);
        chk("ro_value_kept", rd_val, 32'h12345678);
        rd(12'h4, rd_val);
        chk("ro_ctrl_kept", rd_val, 32'h1);
        rd(12'h8, rd_val);
        chk("status_hi_zero", rd_val >> 3, 32'h0);
        rd(12'hC, rd_val);
        chk("off3_zero", rd_val, 32'h0);
        wr(12'h4, 32'hFFFFFFFF);
        rd(12'h4, rd_val);
        chk("ctrl_mask", rd_val, 32'h3);
        sel_i = 1'b0; addr_i = 12'h0;
        #1;
        chk("nosel_rdata", rdata_o, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
